// File: rtl/fpgaol_io_pkg.sv
// Shared definitions for FPGAOL board I/O blocks: LED mode encoding and
// counter-width helper.
package fpgaol_io_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_TOGGLE = 2'd1,
    MODE_ROTATE = 2'd2,
    MODE_COUNT  = 2'd3
  } led_mode_e;

  // Bits needed for a counter that runs 0..n-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Single-bit switch conditioner: 2-flop synchroniser, stability counter and
// registered rising-edge pulse of the debounced level.
module sw_debounce
  import fpgaol_io_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int unsigned   CW      = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          stable_q, stable_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Accept a new level only after DB_CYCLES consecutive deviating samples.
  always_comb begin
    s1_d     = din;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    rise_d = stable_d & ~stable_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = stable_q;
  assign rise = rise_q;

endmodule

// File: rtl/sw_led_ctrl.sv
// Switch-to-LED controller: debounced switches drive LEDs in direct,
// toggle, rotate or edge-count mode; all mode sources run continuously.
module sw_led_ctrl
  import fpgaol_io_pkg::*;
#(
  parameter int unsigned N           = 8,
  parameter int unsigned DB_CYCLES   = 1_000_000,
  parameter int unsigned TICK_CYCLES = 25_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw,
  input  logic [1:0]   mode,
  output logic [N-1:0] led,
  output logic [N-1:0] sw_rise
);

  localparam int unsigned   TW       = cnt_width(TICK_CYCLES);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CYCLES - 1);

  logic [N-1:0]  stable;
  logic [N-1:0]  rise;
  logic [N-1:0]  tog_q, tog_d;
  logic [N-1:0]  rot_q, rot_d;
  logic [N-1:0]  ecnt_q, ecnt_d;
  logic [N-1:0]  led_q, led_d;
  logic [TW-1:0] tick_q, tick_d;
  led_mode_e     mode_prev_q, mode_prev_d;
  led_mode_e     mode_cur;
  logic          any_rise;
  logic          rot_load;

  for (genvar i = 0; i < N; i++) begin : g_db
    sw_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk (clk),
      .rst (rst),
      .din (sw[i]),
      .dout(stable[i]),
      .rise(rise[i])
    );
  end

  assign mode_cur = led_mode_e'(mode);
  assign any_rise = |rise;

  // Mode sources and LED mux; a rotate reload restarts the tick spacing and
  // overrides a coinciding tick. The shift-or form keeps N=1 an identity.
  always_comb begin
    tog_d       = tog_q ^ rise;
    ecnt_d      = ecnt_q + N'(any_rise);
    mode_prev_d = mode_cur;
    rot_load    = (mode_cur == MODE_ROTATE) &&
                  ((mode_prev_q != MODE_ROTATE) || any_rise);
    rot_d       = rot_q;
    tick_d      = tick_q + TW'(1);
    if (rot_load) begin
      rot_d  = stable;
      tick_d = '0;
    end else if (tick_q == TICK_MAX) begin
      rot_d  = (rot_q << 1) | (rot_q >> (N - 1));
      tick_d = '0;
    end
    led_d = led_q;
    case (mode_cur)
      MODE_DIRECT: led_d = stable;
      MODE_TOGGLE: led_d = tog_q;
      MODE_ROTATE: led_d = rot_q;
      MODE_COUNT:  led_d = ecnt_q;
      default:     led_d = stable;
    endcase
  end

  // Registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tog_q       <= '0;
      rot_q       <= '0;
      ecnt_q      <= '0;
      led_q       <= '0;
      tick_q      <= '0;
      mode_prev_q <= MODE_DIRECT;
    end else begin
      tog_q       <= tog_d;
      rot_q       <= rot_d;
      ecnt_q      <= ecnt_d;
      led_q       <= led_d;
      tick_q      <= tick_d;
      mode_prev_q <= mode_prev_d;
    end
  end

  assign led     = led_q;
  assign sw_rise = rise;

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Self-checking bench for sw_led_ctrl (N=8, DB_CYCLES=4, TICK_CYCLES=3).
module tb_sw_led_ctrl;

  localparam int DB   = 4;
  localparam int TICK = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic [1:0] mode;
  logic [7:0] led;
  logic [7:0] sw_rise;

  int total = 0;
  int bad   = 0;

  sw_led_ctrl #(
    .N          (8),
    .DB_CYCLES  (DB),
    .TICK_CYCLES(TICK)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw     (sw),
    .mode   (mode),
    .led    (led),
    .sw_rise(sw_rise)
  );

  always #5 clk = ~clk;

  // Reference model: debounced level flips once the last DB synchronised
  // samples since reset all disagree with it.
  logic [7:0] m_s1 = '0, m_s2 = '0, m_stable = '0, m_rise = '0;
  logic [7:0] m_tog = '0, m_rot = '0, m_ecnt = '0, m_led = '0;
  logic [1:0] m_mode_prev = '0;
  int         m_tick = 0;
  logic [7:0] hist[$];

  function automatic void model_update();
    logic [7:0] nst, n_rot, n_led;
    int         n_tick;
    bit         dev, load;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0; m_tog = '0;
      m_rot = '0; m_ecnt = '0; m_led = '0; m_mode_prev = '0; m_tick = 0;
      hist.delete();
      return;
    end
    hist.push_back(m_s2);
    if (hist.size() > DB) void'(hist.pop_front());
    nst = m_stable;
    for (int i = 0; i < 8; i++) begin
      if (hist.size() == DB) begin
        dev = 1'b1;
        foreach (hist[j]) if (hist[j][i] == m_stable[i]) dev = 1'b0;
        if (dev) nst[i] = ~m_stable[i];
      end
    end
    load = (mode == 2'd2) && ((m_mode_prev != 2'd2) || (m_rise != 0));
    if (load) begin
      n_rot = m_stable; n_tick = 0;
    end else if (m_tick == TICK - 1) begin
      n_rot = 8'((int'(m_rot) * 2) % 256 + int'(m_rot) / 128); n_tick = 0;
    end else begin
      n_rot = m_rot; n_tick = m_tick + 1;
    end
    case (mode)
      2'd0:    n_led = m_stable;
      2'd1:    n_led = m_tog;
      2'd2:    n_led = m_rot;
      default: n_led = m_ecnt;
    endcase
    m_ecnt      = m_ecnt + ((m_rise != 0) ? 8'd1 : 8'd0);
    m_tog       = m_tog ^ m_rise;
    m_rise      = nst & ~m_stable;
    m_stable    = nst;
    m_rot       = n_rot;
    m_tick      = n_tick;
    m_led       = n_led;
    m_mode_prev = mode;
    m_s2        = m_s1;
    m_s1        = sw;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("led_model", led, m_led);
    chk("rise_model", sw_rise, m_rise);
  endtask

  task automatic drive(input logic r, input logic [1:0] md, input logic [7:0] s);
    rst = r; mode = md; sw = s;
  endtask

  task automatic hold(input logic [1:0] md, input logic [7:0] s, input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, md, s);
      step();
    end
  endtask

  typedef struct {
    logic       r;
    logic [1:0] md;
    logic [7:0] s;
    logic [7:0] e_led;
    logic [7:0] e_rise;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic r, input logic [1:0] md, input logic [7:0] s,
                              input logic [7:0] el, input logic [7:0] er, input int n);
    for (int k = 0; k < n; k++) tbl.push_back('{r, md, s, el, er});
  endfunction

  initial begin
    drive(1'b1, 2'd0, 8'h00);

    // Reset with switches high, then release and debounce.
    add(1, 0, 8'hFF, 8'h00, 8'h00, 1);
    add(0, 0, 8'hFF, 8'h00, 8'h00, 5);
    add(0, 0, 8'hFF, 8'h00, 8'hFF, 1);
    add(0, 0, 8'hFF, 8'hFF, 8'h00, 1);
    // 3-cycle glitch on sw[0] is rejected.
    add(1, 0, 8'h00, 8'h00, 8'h00, 1);
    add(0, 0, 8'h01, 8'h00, 8'h00, 3);
    add(0, 0, 8'h00, 8'h00, 8'h00, 7);
    // 4-cycle hold is accepted, then the release debounces back to 0.
    add(0, 0, 8'h01, 8'h00, 8'h00, 4);
    add(0, 0, 8'h00, 8'h00, 8'h00, 1);
    add(0, 0, 8'h00, 8'h00, 8'h01, 1);
    add(0, 0, 8'h00, 8'h01, 8'h00, 4);
    add(0, 0, 8'h00, 8'h00, 8'h00, 1);
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].md, tbl[i].s);
      step();
      chk("tbl_led", led, tbl[i].e_led);
      chk("tbl_rise", sw_rise, tbl[i].e_rise);
    end

    // Toggle: three press/release cycles on sw[2].
    drive(1'b1, 2'd1, 8'h00);
    step();
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 12; k++) begin
        drive(1'b0, 2'd1, (k < 6) ? 8'h04 : 8'h00);
        step();
        if (k == 5) chk("toggle_rise", sw_rise, 8'h04);
        if (k >= 7) chk("toggle_led", led, (p == 1) ? 8'h00 : 8'h04);
        else        chk("toggle_led", led, (p == 1) ? 8'h04 : 8'h00);
      end
    end

    // Rotate: load on mode entry, then steps every TICK cycles.
    hold(2'd1, 8'h81, 8);
    hold(2'd2, 8'h81, 1);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("rot_led", led, (k < 4) ? 8'h81 : (k < 7) ? 8'h03 : (k < 10) ? 8'h06 : 8'h0C);
    end
    for (int k = 0; k <= 10; k++) begin
      drive(1'b0, 2'd2, 8'h91);
      step();
      if (k == 5) chk("rot_reload_rise", sw_rise, 8'h10);
      if (k >= 7 && k <= 9) chk("rot_reload_led", led, 8'h91);
      if (k == 10) chk("rot_after_reload", led, 8'h23);
    end
    hold(2'd2, 8'h00, 6);
    hold(2'd0, 8'h00, 1);
    hold(2'd2, 8'h00, 1);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rot_zero", led, 8'h00);
    end

    // Count: 254 single rises, a simultaneous pair, then a wrapping rise.
    drive(1'b1, 2'd3, 8'h00);
    step();
    for (int r = 0; r < 254; r++) begin
      hold(2'd3, 8'h01, 5);
      hold(2'd3, 8'h00, 5);
    end
    chk("count_254", led, 8'hFE);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 2'd3, 8'h22);
      step();
      if (k == 5) chk("count_pair_rise", sw_rise, 8'h22);
    end
    chk("count_pair", led, 8'hFF);
    hold(2'd3, 8'h00, 8);
    chk("count_fall", led, 8'hFF);
    hold(2'd3, 8'h02, 8);
    chk("count_wrap", led, 8'h00);

    // Mode switch 1 -> 0 shows up one edge later.
    drive(1'b1, 2'd1, 8'h00);
    step();
    hold(2'd1, 8'h08, 8);
    hold(2'd1, 8'h00, 8);
    chk("mode_before", led, 8'h08);
    hold(2'd0, 8'h00, 1);
    chk("mode_after", led, 8'h00);

    // Reset in the middle of a debounce discards the partial count.
    for (int k = 0; k < 10; k++) begin
      drive(k == 3, 2'd0, 8'h01);
      step();
      chk("rst_mid_rise", sw_rise, (k == 9) ? 8'h01 : 8'h00);
    end
    step();
    chk("rst_mid_led", led, 8'h01);

    // Randomised traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      logic [7:0] s;
      logic [1:0] md;
      logic       r;
      s  = sw;
      md = mode;
      if ($urandom_range(0, 3) == 0) s[$urandom_range(0, 7)] = ~s[$urandom_range(0, 7)];
      if ($urandom_range(0, 19) == 0) s = 8'($urandom);
      if ($urandom_range(0, 39) == 0) md = 2'($urandom);
      r = ($urandom_range(0, 499) == 0);
      drive(r, md, s);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
